spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_master.sv | 131 +++++++++++++
 tb/tb_spi_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and companion slave benches:
// FSM state encoding, default timing constants and a sizing helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int HALF_PERIOD_DEF = 8;
  localparam int CS_SETUP_DEF    = 8;
  localparam int CS_HOLD_DEF     = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master.sv
// Mode-0 SPI master moving one byte per transfer, MSB first, with
// programmable cs setup/hold and sclk half-period measured in clk cycles.
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int CS_SETUP    = CS_SETUP_DEF,
  parameter int CS_HOLD     = CS_HOLD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs,
  input  logic [7:0] tx_data,
  input  logic       start,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  localparam int MAX_CNT = max3(HALF_PERIOD, CS_SETUP, CS_HOLD);
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;

  // All outputs are registered so cs/sclk/mosi are glitch-free at the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs       <= 1'b1;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            tx_shift <= tx_data;
            rx_shift <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            cs       <= 1'b0;
            mosi     <= tx_data[7];
            tx_ready <= 1'b0;
          end
        end

        SETUP: begin
          if (div_cnt == SETUP_LAST) begin
            state   <= LOW;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        LOW: begin
          if (div_cnt == HALF_LAST) begin
            state   <= HIGH;
            div_cnt <= '0;
            sclk    <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // miso is captured on the same clk edge that drops sclk; the slave
        // only changes miso after seeing that falling edge.
        HIGH: begin
          if (div_cnt == HALF_LAST) begin
            rx_shift <= {rx_shift[6:0], miso};
            div_cnt  <= '0;
            sclk     <= 1'b0;
            if (bit_cnt == 3'd7) begin
              state <= HOLD;
              mosi  <= 1'b0;
            end else begin
              state    <= LOW;
              tx_shift <= {tx_shift[6:0], 1'b0};
              mosi     <= tx_shift[6];
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (div_cnt == HOLD_LAST) begin
            state    <= IDLE;
            div_cnt  <= '0;
            cs       <= 1'b1;
            tx_ready <= 1'b1;
            rx_data  <= rx_shift;
            rx_done  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          div_cnt  <= '0;
          sclk     <= 1'b0;
          mosi     <= 1'b0;
          cs       <= 1'b1;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural mode-0 slave, waveform
// monitors and a scoreboard of expected master/slave bytes per transfer.
module tb_spi_master;
  import spi_pkg::*;

  localparam int HP = HALF_PERIOD_DEF;
  localparam int SU = CS_SETUP_DEF;
  localparam int HO = CS_HOLD_DEF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk, mosi, miso, cs;
  logic [7:0] tx_data = 8'h00;
  logic       start = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_done;

  spi_master #(.HALF_PERIOD(HP), .CS_SETUP(SU), .CS_HOLD(HO)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cs(cs), .tx_data(tx_data), .start(start), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_done(rx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_si_q[$];

  // Behavioural slave: presents so_data MSB first, shifts on sclk falling,
  // samples mosi on sclk rising.
  logic [7:0] so_data = 8'h00;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic [7:0] s_last = 8'h00;
  int         s_bits = 0;
  int         s_last_bits = 0;

  assign miso = s_tx[7];

  always @(negedge cs) begin
    s_tx   = so_data;
    s_rx   = 8'h00;
    s_bits = 0;
  end
  always @(posedge sclk) if (cs === 1'b0) begin
    s_rx   = {s_rx[6:0], mosi};
    s_bits = s_bits + 1;
  end
  always @(negedge sclk) if (cs === 1'b0) s_tx = {s_tx[6:0], 1'b0};
  always @(posedge cs) begin
    s_last      = s_rx;
    s_last_bits = s_bits;
  end

  // Waveform monitor sampled on the falling clk edge.
  int   cs_run = 0, csh_run = 0, last_cs_low = 0, last_cs_high = 0;
  int   rises = 0, first_rise = 0, hi_run = 0, lo_run = 0;
  int   hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
  int   mosi_ones = 0, done_cnt = 0;
  bit   lo_act = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (cs === 1'b0) begin
      if (prev_cs === 1'b1) begin
        last_cs_high = csh_run;
        cs_run = 0; rises = 0; hi_run = 0; lo_run = 0; lo_act = 0;
        hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0; mosi_ones = 0;
      end
      cs_run++;
      if (mosi === 1'b1) mosi_ones++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        if (rises == 1) first_rise = cs_run - 1;
        if (lo_act) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        lo_act = 0;
        hi_run = 0;
      end
      if (sclk === 1'b1) hi_run++;
      if (sclk === 1'b0 && prev_sclk === 1'b1) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        lo_act = 1;
        lo_run = 0;
      end
      if (sclk === 1'b0 && lo_act) lo_run++;
    end else begin
      if (prev_cs === 1'b0) begin
        last_cs_low = cs_run;
        csh_run = 0;
      end
      csh_run++;
    end
    if (rx_done === 1'b1) done_cnt++;
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 3000) begin tick(); n++; end
    chk("tx_ready_wait", tx_ready, 1'b1);
    tx_data = b;
    start   = 1'b1;
    exp_rx_q.push_back(so_data);
    exp_si_q.push_back(b);
    tick();
    start = 1'b0;
    chk("accepted", tx_ready, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    bit got;
    logic [7:0] er, es;
    got = 0;
    for (int n = 0; n < 3000 && !got; n++) begin
      tick();
      if (rx_done === 1'b1) got = 1;
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    if (got && exp_rx_q.size() > 0) begin
      er = exp_rx_q.pop_front();
      es = exp_si_q.pop_front();
      chk({tag, "_rx_data"}, rx_data, er);
      tick();
      chk({tag, "_done_width"}, rx_done, 1'b0);
      chk({tag, "_slave_rx"}, s_last, es);
      chk({tag, "_slave_bits"}, s_last_bits, 8);
    end
  endtask

  initial begin
    int d0;
    bit hit;

    // Reset state
    tick(); tick();
    chk("rst_cs", cs, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_done", rx_done, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    tick();

    // Basic exchange plus waveform timing
    so_data = 8'h3C;
    d0 = done_cnt;
    do_start(8'hA5);
    wait_done("xfer_a5");
    chk("a5_done_count", done_cnt - d0, 1);
    chk("cs_low_len", last_cs_low, SU + 16 * HP + HO);
    chk("sclk_rises", rises, 8);
    chk("sclk_hi_min", hi_min, HP);
    chk("sclk_hi_max", hi_max, HP);
    chk("sclk_lo_min", lo_min, HP);
    chk("sclk_lo_max", lo_max, HP);
    // SETUP is followed by a full LOW phase before the first rise.
    chk("first_rise", first_rise, SU + HP);

    // start while busy is ignored
    so_data = 8'h96;
    d0 = done_cnt;
    do_start(8'hA5);
    tx_data = 8'hFF;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_done("busy_start");
    repeat (300) tick();
    chk("busy_done_count", done_cnt - d0, 1);
    chk("busy_idle_cs", cs, 1'b1);

    // start held high: two back-to-back transfers
    so_data = 8'h81;
    d0 = done_cnt;
    tx_data = 8'h00;
    start   = 1'b1;
    exp_rx_q.push_back(8'h81); exp_si_q.push_back(8'h00);
    exp_rx_q.push_back(8'h81); exp_si_q.push_back(8'hFF);
    tick();
    tx_data = 8'hFF;
    wait_done("held_first");
    hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      if (tx_ready === 1'b0) hit = 1; else tick();
    end
    start = 1'b0;
    chk("held_second_started", hit, 1'b1);
    wait_done("held_second");
    chk("held_gap_ge1", (last_cs_high >= 1), 1'b1);
    chk("held_done_count", done_cnt - d0, 2);

    // Reset in the middle of bit 3
    so_data = 8'h5A;
    do_start(8'hC3);
    hit = 0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      tick();
      if (rises == 4) hit = 1;
    end
    chk("reach_bit3", hit, 1'b1);
    tick(); tick();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("abort_cs", cs, 1'b1);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_rx_data", rx_data, 8'h00);
    chk("abort_rx_done", rx_done, 1'b0);
    void'(exp_rx_q.pop_front());
    void'(exp_si_q.pop_front());
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("abort_tx_ready", tx_ready, 1'b1);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_rx_hold", rx_data, 8'h00);

    // miso tied high, all-zero transmit
    so_data = 8'hFF;
    do_start(8'h00);
    wait_done("ones");
    chk("ones_mosi_quiet", mosi_ones, 0);
    chk("ones_rises", rises, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
